// File: rtl/ofmap_drain_pkg.sv
// Shared types, constants and the int8 requantization function for the
// ofmap drain path and the int8 tops built on top of it.
package ofmap_pkg;

    localparam int LANES_DEFAULT = 8;
    localparam int IN_W_DEFAULT  = 32;
    localparam int INT8_MAX      = 127;
    localparam int INT8_MIN      = -128;

    typedef logic signed [7:0] q8_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Optional ReLU, round-half-up arithmetic right shift, saturate to int8.
    // The caller sign-extends its lane to 64 bits; working in 65 bits keeps
    // the rounding add from wrapping for any lane width up to 63 bits.
    function automatic q8_t requant(input logic signed [63:0] x,
                                    input logic [4:0]         shift,
                                    input logic               relu);
        logic signed [64:0] v;
        v = 65'(x);
        if (relu && v[64]) begin
            v = '0;
        end
        if (shift != 5'd0) begin
            v = (v + (65'sd1 <<< (shift - 5'd1))) >>> shift;
        end
        if (v > 65'(INT8_MAX)) begin
            return q8_t'(INT8_MAX);
        end else if (v < 65'(INT8_MIN)) begin
            return q8_t'(INT8_MIN);
        end else begin
            return q8_t'(v[7:0]);
        end
    endfunction

endpackage

// File: rtl/ofmap_drain_if.sv
// Output word bus towards the SRAM writer: data/address with valid/ready.
interface ofmap_drain_if #(
    parameter int ADDR_W = 16
);
    logic [31:0]       o_data;
    logic [ADDR_W-1:0] o_addr;
    logic              o_valid;
    logic              i_ready;

    modport master (output o_data, output o_addr, output o_valid, input i_ready);
    modport slave  (input o_data, input o_addr, input o_valid, output i_ready);
endinterface

// File: rtl/ofmap_drain_fifo.sv
// Synchronous vector FIFO with simultaneous push/pop. Occupancy is tracked
// with one extra pointer bit so full and empty are distinguishable.
module ofmap_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [W-1:0]   wdata,
    output logic [W-1:0]   rdata,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] level
);

    logic [W-1:0]   mem_reg [0:DEPTH-1];
    logic [PTR_W:0] wr_ptr_reg;
    logic [PTR_W:0] rd_ptr_reg;

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg[PTR_W-1:0]] <= wdata;
        end
    end

    // Pointer update; pushing into a full FIFO is legal only alongside a pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign rdata = mem_reg[rd_ptr_reg[PTR_W-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/ofmap_drain.sv
// PE-array output drain: requantizes each incoming partial-sum vector to
// int8, buffers whole vectors, and streams them out four lanes per word
// with auto-incrementing addresses.
module ofmap_drain
    import ofmap_pkg::*;
#(
    parameter int LANES  = LANES_DEFAULT,
    parameter int IN_W   = IN_W_DEFAULT,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [ADDR_W-1:0]      i_base_addr,
    input  logic [4:0]             i_shift,
    input  logic                   i_relu,
    input  logic                   i_valid,
    input  logic signed [IN_W-1:0] i_ofmap [0:LANES-1],
    ofmap_drain_if.master          bus,
    output logic                   o_overflow,
    output logic [15:0]            o_count,
    output logic                   o_busy
);

    localparam int VEC_W = LANES * 8;
    localparam int WORDS = LANES / 4;
    localparam int W_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    state_t            state_reg, state_next;
    logic [W_W-1:0]    w_reg, w_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [15:0]       count_reg;
    logic              ovf_reg;

    logic [VEC_W-1:0]  qvec;
    logic [VEC_W-1:0]  head;
    logic              fifo_full, fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic              push_acc, pop, accept, more, w_last, start_ok;
    logic [31:0]       words [0:WORDS-1];

    // Requantize every lane on the way into the FIFO, so shift/relu are
    // captured with the vector they apply to.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_quant
        assign qvec[gi*8 +: 8] = requant(64'(i_ofmap[gi]), i_shift, i_relu);
    end

    // View the head vector as a word array; lane 4k+j lands in byte j of word k.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
        assign words[gi] = head[gi*32 +: 32];
    end

    ofmap_fifo #(
        .W     (VEC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_acc),
        .pop   (pop),
        .wdata (qvec),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // The PE array cannot stall, so a vector arriving into a full FIFO is
    // kept only if the head leaves in the same cycle.
    assign push_acc = i_valid && (!fifo_full || pop);
    assign w_last   = (w_reg == W_W'(WORDS - 1));
    assign more     = (fifo_level > LVL_W'(1)) || push_acc;
    assign start_ok = i_start && (state_reg == ST_IDLE) && fifo_empty;

    // FSM state and word index register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            w_reg     <= '0;
        end else begin
            state_reg <= state_next;
            w_reg     <= w_next;
        end
    end

    // Next state: stay in SEND across vectors to avoid a bubble between them.
    always_comb begin
        state_next = state_reg;
        w_next     = w_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_next = ST_SEND;
                    w_next     = '0;
                end
            end
            ST_SEND: begin
                if (bus.i_ready) begin
                    if (w_last) begin
                        w_next     = '0;
                        state_next = more ? ST_SEND : ST_IDLE;
                    end else begin
                        w_next = w_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                w_next     = '0;
            end
        endcase
    end

    // FSM outputs: present the current word and pop after its last word.
    always_comb begin
        bus.o_valid = (state_reg == ST_SEND);
        bus.o_data  = '0;
        accept      = 1'b0;
        pop         = 1'b0;
        if (state_reg == ST_SEND) begin
            bus.o_data = words[w_reg];
            accept     = bus.i_ready;
            pop        = bus.i_ready && w_last;
        end
    end

    // Address, drained-vector count and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_reg  <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (start_ok) begin
            addr_reg  <= i_base_addr;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            if (accept) begin
                addr_reg <= addr_reg + 1'b1;
            end
            if (pop) begin
                count_reg <= count_reg + 1'b1;
            end
            if (i_valid && !push_acc) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign bus.o_addr = addr_reg;
    assign o_count    = count_reg;
    assign o_overflow = ovf_reg;
    assign o_busy     = !fifo_empty || bus.o_valid;

endmodule

// File: doc/ofmap_drain.md
Name: ofmap_drain

Overview:
- Consumer end of the PE block output interface. It accepts the 8-lane 32-bit partial-sum vector presented with a one-cycle valid, requantizes each lane to int8 (optional ReLU, rounding shift, saturation), and packs four lanes per 32-bit word.
- Packed words go to the output SRAM writer over a valid/ready handshake with auto-incrementing addresses.
- The PE array has no backpressure, so the block buffers whole vectors in a small FIFO and flags overflow.

Parameters:
- LANES, 8, lanes per result vector (must be a multiple of 4)
- IN_W, 32, width of each incoming lane
- DEPTH, 4, FIFO depth in vectors (power of 2, ≥2)
- ADDR_W, 16, output word address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- i_start  in  1  pulse: load i_base_addr, clear counters and overflow flag
- i_base_addr  in  ADDR_W  first output word address
- i_shift  in  5  right-shift amount for requantization
- i_relu  in  1  1 = clamp negative lanes to 0 before shifting
- i_valid  in  1  input vector valid (single-cycle strobe)
- i_ofmap  in  LANES x IN_W  unpacked array [0:LANES-1] of signed partial sums
- o_data  out  32  packed int8 word; lane 4k+j in bits [8j+7:8j]
- o_addr  out  ADDR_W  word address for o_data
- o_valid  out  1  output word valid
- i_ready  in  1  downstream accept
- o_overflow  out  1  sticky: a vector was dropped
- o_count  out  16  vectors fully drained since i_start
- o_busy  out  1  FIFO non-empty or a word is pending

Behaviour:
- Reset (rst=0 at a clk edge):
  - FIFO emptied, FSM to IDLE, address register = 0.
  - All outputs 0.
  - Reset mid-transfer abandons the in-flight vector without completing it.
- i_start:
  - Ignored unless the FSM is IDLE and the FIFO is empty.
  - When accepted: o_addr ← i_base_addr, o_count ← 0, o_overflow ← 0.
- Requantization (combinational on the FIFO write path), per lane x, signed:
  - If i_relu and x<0, then x=0.
  - If i_shift>0, y = (x + (1<<(i_shift-1))) >>> i_shift, computed in IN_W+1 bits so the rounding add cannot wrap. If i_shift=0, y = x.
  - Saturate y to [-128,127].
- FIFO:
  - Stores requantized vectors of LANES×8 bits.
  - Push on i_valid.
  - Pop when the last word of the head vector is accepted.
  - When full, push succeeds only if a pop occurs in the same cycle. Otherwise the vector is dropped and o_overflow is set.
  - Pointers wrap modulo DEPTH. Occupancy is tracked with an extra pointer bit.
- Output FSM, states IDLE and SEND:
  - Word index w runs 0 to LANES/4-1.
  - IDLE: if the FIFO is non-empty, go to SEND with w=0. o_valid rises in the next cycle.
  - SEND: o_valid=1 and o_data = bytes 4w..4w+3 of the FIFO head. o_data and o_addr stay stable while o_valid=1 and i_ready=0.
  - On o_valid & i_ready: o_addr increments. If w is the last word, pop, increment o_count, then go to SEND with w=0 if the FIFO has another vector, else IDLE. Otherwise w increments.
  - o_addr wraps modulo 2^ADDR_W.
- Latency and throughput:
  - i_valid at cycle t gives o_valid at t+2 (push at t, IDLE→SEND at t+1, word visible at t+2).
  - Sustained rate with i_ready=1 is LANES/4 words per vector, with no idle bubble between back-to-back vectors.
- i_shift and i_relu are sampled at push time; changing them affects only later vectors.
- o_busy = FIFO non-empty | o_valid.

Decomposition:
- Shared package ofmap_pkg holds:
  - LANES_DEFAULT and IN_W_DEFAULT constants
  - INT8_MAX=127 and INT8_MIN=-128
  - typedef logic signed [7:0] q8_t
  - a requant function (relu, round, saturate) reused by the future int8 top
- One natural sub-module: ofmap_fifo, a synchronous vector FIFO with full/empty and simultaneous push/pop.

Test Plan:
- Base 0x0100, shift 0, relu 0, i_ready=1, one vector lanes = {1,2,3,4,5,6,7,8} → o_data 0x04030201 @0x0100 at t+2, then 0x08070605 @0x0101; o_count=1; o_busy falls.
- Lanes {300,-300,-5,127,…}, shift 0 → bytes 0x7F,0x80,0xFB,0x7F (saturation). Repeat with relu=1 → 0x7F,0x00,0x00,0x7F.
- Lane 6, shift 2 → 2 (round half up). Lane -6, shift 2 → -1 (0xFF). Lane 0x7FFFFFFF, shift 4 → 0x7F, with no wrap in the rounding add.
- i_ready=0 while 5 vectors arrive on consecutive cycles (DEPTH=4) → o_overflow=1 after the 5th. The held word stays stable. After releasing i_ready, exactly 8 words are written at consecutive addresses and o_count=4.
- FIFO full with i_ready=1 so the head pops exactly as a new i_valid arrives → vector accepted and o_overflow stays 0.
- Assert rst low while in SEND with w=1 → next cycle o_valid=0, o_count=0, FIFO empty. A new i_start then a vector restarts cleanly at i_base_addr.
